instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the decode-stage immediate extraction: packs an opcode, register fields and a 64-bit signed immediate into a 32-bit LEGv8 instruction word.
- Range-checks the immediate against its target field, then streams accepted words into instruction memory at consecutive byte addresses.
- Serves as the boot/program loader ahead of the fetch stage, and as the bench's instruction generator.

Parameters:
- ADDR_W, 64, instruction-memory byte-address width
- BASE_ADDR, 0, first write address after start
- MAX_WORDS, 256, capacity in words; last legal address is BASE_ADDR+4*(MAX_WORDS-1)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a load session
- finish  in  1  pulse; ends the session
- req_valid  in  1  encode request valid
- req_ready  out  1  request accepted when valid&ready
- req_fmt  in  2  0=D (LDUR/STUR), 1=CB (CBZ), 2=B, 3=RAW
- req_opcode  in  11  opcode, left-aligned as in instruction[31:21]
- req_rt  in  5  Rt
- req_rn  in  5  Rn
- req_imm  in  64  signed immediate (RAW: word in [31:0])
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  byte address
- imem_wdata  out  32  encoded word
- busy  out  1  session active
- done  out  1  session ended (finish or full)
- err  out  1  sticky range error
- err_addr  out  ADDR_W  address slot of the first rejected request
- word_count  out  16  words written this session

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs are 0, except imem_addr = BASE_ADDR and req_ready = 0.
- States: IDLE, ACTIVE, DONE.
  - IDLE --start--> ACTIVE. Clears err, err_addr, word_count and done; sets the address pointer to BASE_ADDR.
  - ACTIVE --finish or pointer passes last address--> DONE.
  - DONE --start--> ACTIVE with the same clears.
  - start while ACTIVE restarts the session the same way. Any in-flight write still completes at its old address.
- req_ready = 1 only in ACTIVE, and only while the pointer is ≤ the last legal address. It depends on registered state only.
- Encoding (registered stage, latency 1):
  - D: {opcode[10:0], imm[8:0], 2'b00, rn, rt}. Legal when -256 ≤ imm ≤ 255.
  - CB: {opcode[10:3], imm[18:0], rt}. Legal when -2^18 ≤ imm ≤ 2^18-1.
  - B: {opcode[10:5], imm[25:0]}. Legal when -2^25 ≤ imm ≤ 2^25-1.
  - RAW: imm[31:0]. Legal when imm[63:32] == 0.
  - Range test: imm[63:N-1] is all zeros or all ones, where N is the field width.
- Accepted legal beat in cycle T:
  - imem_we=1, imem_addr=pointer, imem_wdata=word in cycle T+1.
  - pointer += 4 and word_count += 1 on the same edge as acceptance.
- Accepted illegal beat:
  - No write; pointer unchanged; err set.
  - err_addr is captured only if err was 0.
- Back-to-back accepts give a write every cycle. imem_we is a single-cycle pulse per word.
- Full: when the accept writes the last legal address, req_ready drops the next cycle and the state goes to DONE after that write.
- finish arriving with an accept in the same cycle: the beat is accepted and written, then the state goes to DONE.
- finish in IDLE or DONE: ignored.
- Reset mid-write: the write is dropped and all outputs return to reset values immediately.
- Round-trip property: for any legal D/CB/B request, the decode-stage extension of imem_wdata equals req_imm.

Test Plan:
- Reset, start, one D request (opcode 11'h7C2 LDUR, imm=-4, rn=1, rt=2) -> one cycle later: imem_we=1, addr=0, wdata=32'hF85FC022; word_count=1.
- Three back-to-back accepts: CB imm=0x3FFFF, B imm=-1, RAW 0xD503201F -> writes at addr 0, 4, 8 on consecutive cycles. Words: {opcode[10:3],19'h3FFFF,rt}, {opcode[10:5],26'h3FFFFFF}, 32'hD503201F.
- D imm=256 at slot 4, then D imm=-257 -> no writes, err=1, err_addr=4, pointer stays 4, next legal write goes to addr 4.
- MAX_WORDS=4, hold req_valid high -> exactly 4 writes (addr 0..12), req_ready=0 afterwards, done=1, word_count=4.
- finish coincident with accept -> that word is written, then done=1, req_ready=0. A later start resets addr to 0, clears err, and sets word_count=0.
- Assert reset_n low in the cycle after an accept -> no imem_we pulse, all outputs zero immediately (asynchronous).

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Packs LEGv8 D/CB/B/RAW requests into 32-bit instruction words and streams
// range-checked words into instruction memory at consecutive byte addresses.
module instr_encoder_loader #(
  parameter int                 ADDR_W    = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int                 MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_fmt,
  input  logic [10:0]       req_opcode,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rn,
  input  logic [63:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       word_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(4 * (MAX_WORDS - 1));

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              legal;
  logic [31:0]       word;
  logic              accept;

  // Handshake: a beat transfers on a cycle where req_valid && req_ready;
  // req_ready comes from registered state only, so it never depends on req_valid.
  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACTIVE;
      ACTIVE: begin
        if (start)                          state_nxt = ACTIVE;
        else if (finish || (ptr > LAST_ADDR)) state_nxt = DONE;
      end
      DONE:    if (start) state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ACTIVE) && (ptr <= LAST_ADDR);
    busy      = (state == ACTIVE);
    done      = (state == DONE);
    state_dbg = state;
  end

  // Field packing; a field of width N is legal when imm[63:N-1] is a pure sign extension.
  always_comb begin
    legal = 1'b0;
    word  = '0;
    case (req_fmt)
      2'd0: begin
        legal = (&req_imm[63:8]) || !(|req_imm[63:8]);
        word  = {req_opcode, req_imm[8:0], 2'b00, req_rn, req_rt};
      end
      2'd1: begin
        legal = (&req_imm[63:18]) || !(|req_imm[63:18]);
        word  = {req_opcode[10:3], req_imm[18:0], req_rt};
      end
      2'd2: begin
        legal = (&req_imm[63:25]) || !(|req_imm[63:25]);
        word  = {req_opcode[10:5], req_imm[25:0]};
      end
      default: begin
        legal = !(|req_imm[63:32]);
        word  = req_imm[31:0];
      end
    endcase
  end

  // A restart resets the session bookkeeping, but a beat accepted in the same
  // cycle is still written at the address it was accepted for.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      ptr        <= BASE_ADDR;
      word_count <= '0;
      err        <= 1'b0;
      err_addr   <= '0;
    end else begin
      we_q <= accept && legal;
      if (accept && legal) begin
        addr_q  <= ptr;
        wdata_q <= word;
      end
      if (start) begin
        ptr        <= BASE_ADDR;
        word_count <= '0;
        err        <= 1'b0;
        err_addr   <= '0;
      end else if (accept) begin
        if (legal) begin
          ptr        <= ptr + ADDR_W'(4);
          word_count <= word_count + 16'd1;
        end else begin
          err <= 1'b1;
          if (!err) err_addr <= ptr;
        end
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (MAX_WORDS=4) with hand-computed words.
module tb_instr_encoder_loader;

  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          finish = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_fmt = '0;
  logic [10:0]   req_opcode = '0;
  logic [4:0]    req_rt = '0;
  logic [4:0]    req_rn = '0;
  logic [63:0]   req_imm = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] err_addr;
  logic [15:0]   word_count;
  logic [1:0]    state_dbg;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR('0), .MAX_WORDS(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
    .req_opcode(req_opcode), .req_rt(req_rt), .req_rn(req_rn), .req_imm(req_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .word_count(word_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] fmt, input logic [10:0] op,
                         input logic [4:0] rt, input logic [4:0] rn, input logic [63:0] imm);
    req_valid  = 1'b1;
    req_fmt    = fmt;
    req_opcode = op;
    req_rt     = rt;
    req_rn     = rn;
    req_imm    = imm;
  endtask

  // One-cycle request; on return the write (if any) is visible.
  task automatic send(input logic [1:0] fmt, input logic [10:0] op,
                      input logic [4:0] rt, input logic [4:0] rn, input logic [63:0] imm);
    set_req(fmt, op, rt, rn, imm);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 64'(imem_we), 64'd0);
    check({tag, "_addr"}, imem_addr, 64'd0);
    check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_err_addr"}, err_addr, 64'd0);
    check({tag, "_wc"}, 64'(word_count), 64'd0);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'd0);
  endtask

  initial begin
    int nwrites;
    logic [63:0] exp_addr;

    // Reset values
    #2;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // finish in IDLE is ignored
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("idle_finish_done", 64'(done), 64'd0);
    check("idle_finish_busy", 64'(busy), 64'd0);

    // Single LDUR
    do_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_ready", 64'(req_ready), 64'd1);
    send(2'd0, 11'h7C2, 5'd2, 5'd1, -64'sd4);
    check("ldur_we", 64'(imem_we), 64'd1);
    check("ldur_addr", imem_addr, 64'd0);
    check("ldur_wdata", 64'(imem_wdata), 64'hF85FC022);
    check("ldur_wc", 64'(word_count), 64'd1);
    @(negedge clk);
    check("ldur_we_pulse", 64'(imem_we), 64'd0);

    // Back-to-back CB / B / RAW
    do_start();
    check("restart_wc", 64'(word_count), 64'd0);
    exp_q.push_back(32'hB47FFFE3);
    exp_q.push_back(32'h17FFFFFF);
    exp_q.push_back(32'hD503201F);
    set_req(2'd1, 11'h5A0, 5'd3, 5'd0, 64'h3FFFF);
    @(negedge clk);
    check("b2b0_we", 64'(imem_we), 64'd1);
    check("b2b0_addr", imem_addr, 64'd0);
    check("b2b0_wdata", 64'(imem_wdata), 64'(exp_q.pop_front()));
    set_req(2'd2, 11'h0A0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("b2b1_we", 64'(imem_we), 64'd1);
    check("b2b1_addr", imem_addr, 64'd4);
    check("b2b1_wdata", 64'(imem_wdata), 64'(exp_q.pop_front()));
    set_req(2'd3, 11'h000, 5'd0, 5'd0, 64'hD503201F);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b2_we", 64'(imem_we), 64'd1);
    check("b2b2_addr", imem_addr, 64'd8);
    check("b2b2_wdata", 64'(imem_wdata), 64'(exp_q.pop_front()));
    check("b2b_wc", 64'(word_count), 64'd3);

    // Range errors on D
    do_start();
    send(2'd0, 11'h7C0, 5'd0, 5'd0, 64'd255);
    check("d255_wdata", 64'(imem_wdata), 64'hF80FF000);
    check("d255_addr", imem_addr, 64'd0);
    send(2'd0, 11'h7C2, 5'd2, 5'd1, 64'd256);
    check("d256_we", 64'(imem_we), 64'd0);
    check("d256_err", 64'(err), 64'd1);
    check("d256_err_addr", err_addr, 64'd4);
    send(2'd0, 11'h7C2, 5'd2, 5'd1, -64'sd257);
    check("dm257_we", 64'(imem_we), 64'd0);
    check("dm257_err_addr", err_addr, 64'd4);
    check("dm257_wc", 64'(word_count), 64'd1);
    send(2'd0, 11'h7C2, 5'd2, 5'd1, -64'sd256);
    check("dm256_we", 64'(imem_we), 64'd1);
    check("dm256_addr", imem_addr, 64'd4);
    check("dm256_wdata", 64'(imem_wdata), 64'hF8500022);
    check("dm256_err_sticky", 64'(err), 64'd1);

    // Fill to capacity with req_valid held high
    do_start();
    set_req(2'd3, 11'h000, 5'd0, 5'd0, 64'h12345678);
    nwrites = 0;
    exp_addr = 64'd0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (imem_we) begin
        check("full_addr", imem_addr, exp_addr);
        exp_addr += 64'd4;
        nwrites++;
      end
    end
    req_valid = 1'b0;
    check("full_nwrites", 64'(nwrites), 64'd4);
    check("full_ready", 64'(req_ready), 64'd0);
    check("full_done", 64'(done), 64'd1);
    check("full_wc", 64'(word_count), 64'd4);

    // finish coincident with accept, then restart clears
    do_start();
    send(2'd2, 11'h0A0, 5'd0, 5'd0, 64'h200_0000);
    check("b_oor_err", 64'(err), 64'd1);
    check("b_oor_we", 64'(imem_we), 64'd0);
    finish = 1'b1;
    send(2'd3, 11'h000, 5'd0, 5'd0, 64'hCAFEF00D);
    finish = 1'b0;
    check("fin_we", 64'(imem_we), 64'd1);
    check("fin_addr", imem_addr, 64'd0);
    check("fin_wdata", 64'(imem_wdata), 64'hCAFEF00D);
    check("fin_done", 64'(done), 64'd1);
    check("fin_ready", 64'(req_ready), 64'd0);
    do_start();
    check("restart_err", 64'(err), 64'd0);
    check("restart_wc2", 64'(word_count), 64'd0);
    check("restart_done", 64'(done), 64'd0);
    send(2'd3, 11'h000, 5'd0, 5'd0, 64'h0000_0001);
    check("restart_addr", imem_addr, 64'd0);

    // Asynchronous reset right after an accept
    set_req(2'd3, 11'h000, 5'd0, 5'd0, 64'hAAAA5555);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check("midrst_we_hold", 64'(imem_we), 64'd0);
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
